// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter stage that sits directly behind the jump-decision block.
// It takes that block's registered jump request and target and presents a
// fetch address with a valid/ready handshake to instruction fetch. A taken
// jump always passes through a one-cycle FLUSH state, so fetch never sees a
// stale sequential PC after a redirect.
//
// States (visible on state_o): IDLE=0, RUN=1, FLUSH=2, HALT=3.
//
// Optional feature macro: PC_SEQ_LINK_EN
//   When defined, adds call/ret inputs and a link_pc output. A jump with
//   call=1 records pc+1 in link_pc. A ret without a jump redirects to link_pc.
//   When undefined, those ports do not exist.
//
// Parameters:
//   PC_WIDTH  width of pc, jump_target and link_pc (pc wraps modulo 2**PC_WIDTH)
//   RESET_PC  pc value loaded on reset
//
// Ports:
//   clk          in   1         clock; all state updates on posedge
//   reset        in   1         synchronous, active-high reset
//   enable       in   1         run request; 0 parks in IDLE holding pc
//   jump         in   1         taken-jump request (level, sampled per cycle)
//   jump_target  in   PC_WIDTH  destination address when jump=1
//   halt         in   1         stop fetching; sticky until reset
//   fetch_ready  in   1         fetch accepts pc this cycle
//   call         in   1         (PC_SEQ_LINK_EN) record return address on jump
//   ret          in   1         (PC_SEQ_LINK_EN) return to link_pc
//   pc           out  PC_WIDTH  current fetch address
//   pc_valid     out  1         pc is a valid fetch request (RUN only)
//   flush        out  1         one-cycle pulse after a taken redirect
//   wrap         out  1         one-cycle pulse when pc increments all-ones -> 0
//   link_pc      out  PC_WIDTH  (PC_SEQ_LINK_EN) saved return address
//   state_o      out  2         encoded state
// ============================================================================
module pc_sequencer #(
    parameter int unsigned PC_WIDTH = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt,
    input  logic                fetch_ready,
`ifdef PC_SEQ_LINK_EN
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] link_pc,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic                flush,
    output logic                wrap,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

    // Sequential successor of a pc; natural modulo 2**PC_WIDTH wrap.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] v);
        return v + PC_WIDTH'(1);
    endfunction

    // True when incrementing v wraps back to zero.
    function automatic logic pc_wraps(input logic [PC_WIDTH-1:0] v);
        return &v;
    endfunction

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                flush_q, flush_d;
    logic                wrap_q, wrap_d;
`ifdef PC_SEQ_LINK_EN
    logic [PC_WIDTH-1:0] link_pc_q, link_pc_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        wrap_d  = 1'b0;
`ifdef PC_SEQ_LINK_EN
        link_pc_d = link_pc_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // halt and !enable freeze pc and swallow any jump that cycle.
                if (halt) begin
                    state_d = ST_HALT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (jump) begin
                    // Redirect does not wait for fetch_ready: the in-flight
                    // address is discarded by the flush pulse anyway.
                    pc_d    = jump_target;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
`ifdef PC_SEQ_LINK_EN
                    if (call) begin
                        link_pc_d = pc_inc(pc_q);
                    end
                end else if (ret) begin
                    pc_d    = link_pc_q;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
`endif
                end else if (fetch_ready) begin
                    pc_d   = pc_inc(pc_q);
                    wrap_d = pc_wraps(pc_q);
                end
                // Otherwise backpressure: pc held stable while valid.
            end

            ST_FLUSH: begin
                state_d = halt ? ST_HALT : ST_RUN;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_V;
            flush_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef PC_SEQ_LINK_EN
            link_pc_q <= RESET_PC_V;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            wrap_q  <= wrap_d;
`ifdef PC_SEQ_LINK_EN
            link_pc_q <= link_pc_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign flush    = flush_q;
    assign wrap     = wrap_q;
    assign state_o  = state_q;
`ifdef PC_SEQ_LINK_EN
    assign link_pc  = link_pc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int PW   = 4;
    localparam int MODN = 1 << PW;
`ifdef PC_SEQ_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, jump, halt, fetch_ready, call, ret;
    logic [PW-1:0] jump_target;
    logic [PW-1:0] pc;
    logic          pc_valid, flush, wrap;
    logic [1:0]    state_o;
    logic [PW-1:0] link_pc;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode is 0 idle, 1 run, 2 flush, 3 halt.
    int m_mode, m_pc, m_link;
    bit m_flush, m_wrap;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .jump       (jump),
        .jump_target(jump_target),
        .halt       (halt),
        .fetch_ready(fetch_ready),
`ifdef PC_SEQ_LINK_EN
        .call       (call),
        .ret        (ret),
        .link_pc    (link_pc),
`endif
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .wrap       (wrap),
        .state_o    (state_o)
    );

`ifndef PC_SEQ_LINK_EN
    assign link_pc = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance model by the specification's rules,
    // then compare every output shortly after the edge.
    task automatic step(input bit rst, input bit en, input bit jmp, input int tgt,
                        input bit hlt, input bit rdy, input bit cl, input bit rt);
        reset = rst; enable = en; jump = jmp; jump_target = PW'(tgt);
        halt = hlt; fetch_ready = rdy; call = cl; ret = rt;
        @(posedge clk);
        m_flush = 0;
        m_wrap  = 0;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_link = 0;
        end else if (m_mode == 0) begin
            if (hlt) m_mode = 3;
            else if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (hlt) m_mode = 3;
            else if (!en) m_mode = 0;
            else if (jmp) begin
                if (LINK_EN && cl) m_link = (m_pc + 1) % MODN;
                m_pc = tgt % MODN; m_flush = 1; m_mode = 2;
            end else if (LINK_EN && rt) begin
                m_pc = m_link; m_flush = 1; m_mode = 2;
            end else if (rdy) begin
                m_wrap = (m_pc == MODN - 1);
                m_pc   = (m_pc + 1) % MODN;
            end
        end else if (m_mode == 2) begin
            m_mode = hlt ? 3 : 1;
        end
        #1;
        check("pc", pc, m_pc);
        check("pc_valid", pc_valid, m_mode == 1);
        check("flush", flush, m_flush);
        check("wrap", wrap, m_wrap);
        check("state", state_o, m_mode);
        check("flush_wrap_excl", flush & wrap, 0);
        if (LINK_EN) check("link_pc", link_pc, m_link);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;
        m_mode = 0; m_pc = 0; m_link = 0; m_flush = 0; m_wrap = 0;
        reset = 1; enable = 0; jump = 0; jump_target = '0;
        halt = 0; fetch_ready = 0; call = 0; ret = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 0);
        check("rst_state", state_o, 0);
        check("rst_valid", pc_valid, 0);

        // 17 cycles of run with fetch always ready: 0..15,0 with one wrap
        wraps = 0;
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 0, 0, 0, 1, 0, 0);
            check("seq_pc", pc, i % 16);
            check("seq_valid", pc_valid, 1);
            if (wrap) wraps++;
        end
        check("wrap_count", wraps, 1);

        // Advance to pc=5, then backpressure for 3 cycles
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
        check("at5", pc, 5);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0);
            check("bp_hold", pc, 5);
            check("bp_valid", pc_valid, 1);
        end
        step(0, 1, 0, 0, 0, 1, 0, 0);
        check("bp_resume", pc, 6);

        // To pc=3, then jump to 12
        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
        check("at3", pc, 3);
        step(0, 1, 1, 12, 0, 1, 0, 0);
        check("jmp_pc", pc, 12);
        check("jmp_flush", flush, 1);
        check("jmp_valid", pc_valid, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        check("post_flush_valid", pc_valid, 1);
        check("post_flush_pc", pc, 12);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        check("post_flush_inc", pc, 13);

        // To pc=7, halt and jump together
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
        check("at7", pc, 7);
        step(0, 1, 1, 2, 1, 1, 0, 0);
        check("halt_pc", pc, 7);
        check("halt_state", state_o, 3);
        check("halt_flush", flush, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 9, 0, 1, 0, 0);
        check("halt_sticky", state_o, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("halt_rst_pc", pc, 0);
        check("halt_rst_state", state_o, 0);

        // Reset during FLUSH after a jump to 9
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 9, 0, 1, 0, 0);
        check("flush_pc9", pc, 9);
        step(1, 1, 0, 0, 0, 1, 0, 0);
        check("rst_in_flush_pc", pc, 0);
        check("rst_in_flush_fl", flush, 0);
        check("rst_in_flush_st", state_o, 0);

        // Call/return (link feature only)
        if (LINK_EN) begin
            step(0, 1, 0, 0, 0, 1, 0, 0);
            for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
            check("at4", pc, 4);
            step(0, 1, 1, 10, 0, 1, 1, 0);
            check("call_link", link_pc, 5);
            step(0, 1, 0, 0, 0, 1, 0, 0);
            step(0, 1, 0, 0, 0, 1, 0, 0);
            check("at11", pc, 11);
            step(0, 1, 0, 0, 0, 1, 0, 1);
            check("ret_pc", pc, 5);
            check("ret_flush", flush, 1);
        end

        // Randomized traffic against the model
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit rr;
            rr = ($urandom % 64 == 0) || (m_mode == 3 && $urandom % 4 == 0);
            step(rr, $urandom % 8 != 0, $urandom % 5 == 0, $urandom % MODN,
                 $urandom % 60 == 0, $urandom % 3 != 0, $urandom % 2 == 1,
                 $urandom % 6 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
